instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Program loader that writes the instruction memory from a byte stream before the core runs. Accepts a word count and a little-endian byte stream over a valid/ready handshake, and assembles 32-bit words. Issues one single-cycle write per word on the instruction memory's write port, at consecutive word indices starting at 0. Holds the core stalled (`core_hold`) for the whole load.

## Interface
- `MEMORY_SIZE`, 64: instruction memory depth in 32-bit words; the largest legal `word_count`.
- `clk`  in  1  rising-edge clock, shared with the instruction memory.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin a load; sampled on `clk`.
- `word_count`  in  32  number of words to load; captured on an accepted `start`.
- `byte_in`  in  8  stream data byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  the loader accepts a byte this cycle.
- `write_en`  out  1  single-cycle write strobe to the instruction memory.
- `write_address`  out  32  word index (not byte address), 0..`MEMORY_SIZE`-1.
- `write_data`  out  32  assembled instruction word.
- `core_hold`  out  1  keeps the core stalled while loading.
- `busy`  out  1  a load is in progress.
- `done`  out  1  the last load completed; sticky.
- `error`  out  1  the last `start` was rejected; sticky.

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE.
- IDLE / DONE, `start`=1:
  - If `word_count` is 0 or greater than `MEMORY_SIZE`: set `error`=1, clear `done`, go to IDLE. No writes are issued.
  - Otherwise: capture the count, clear the word index, byte counter, `done` and `error`, then go to COLLECT.
- COLLECT:
  - `byte_ready`=1.
  - Each handshake (`byte_valid` & `byte_ready` at a rising edge) stores `byte_in` into lane `byte_cnt`. Byte 0 goes to [7:0], byte 3 to [31:24].
  - `byte_cnt` increments modulo 4.
  - The handshake that carries byte 3 moves the FSM to WRITE.
- WRITE:
  - Lasts exactly one cycle, with `byte_ready`=0.
  - `write_en`=1, `write_address`=current word index, `write_data`=assembled word.
  - Next state: if the index equals count-1, go to DONE; otherwise increment the index and go to COLLECT.
- DONE: `done`=1 and `busy`=0; stays here until the next `start`.
- `start` in COLLECT or WRITE is ignored.
- `core_hold` = `busy` = (state is COLLECT or WRITE).
- Outside WRITE: `write_en`=0. `write_address` and `write_data` hold their last values; only `write_en` qualifies them.
- Word index arithmetic is 32-bit. The index never exceeds `MEMORY_SIZE`-1 because the count is range-checked at `start`.
- Byte stalls: `byte_valid` low for any number of cycles just pauses assembly. No timeout.

## Timing
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - `byte_ready`, `write_en`, `core_hold`, `busy`, `done`, `error` are 0.
  - `write_address` and `write_data` are 0.
  - The byte counter, word index and assembly register are cleared.
- Reset mid-load: any partial word is discarded and words already written stay in memory. After reset deasserts, a fresh `start` is required.
- `start` accepted at edge N: from cycle N+1, `busy`=`core_hold`=`byte_ready`=1.
- Byte 3 accepted at edge M: `write_en`=1 during cycle M+1 and the memory captures the word at edge M+2. `byte_ready`=0 in cycle M+1 and returns to 1 in cycle M+2 unless the load is complete.
- Peak throughput: one word per 5 cycles (4 handshakes plus 1 WRITE cycle).
- Final WRITE cycle at K: `done`=1 and `busy`=`core_hold`=0 from cycle K+1.
- Rejected `start` at edge N: `error`=1 from cycle N+1. No other output changes except that `done` is cleared.

## Test plan
- Reset values: assert `reset` asynchronously mid-cycle -> all outputs 0 immediately. Hold reset 3 cycles, release -> still IDLE and `byte_ready`=0.
- Single-word load: `start`, `word_count`=1, bytes 0x13,0x05,0x10,0x00 streamed back-to-back -> exactly one `write_en` pulse with `write_address`=0 and `write_data`=0x00100513. Then `done`=1, `core_hold`=0.
- Full memory with stalls: `word_count`=64, word i = 0xA5000000+i, `byte_valid` toggling randomly -> 64 write pulses, addresses 0..63 in order with matching data. `byte_ready`=0 in every WRITE cycle. `done` set after word 63 only.
- Range errors:
  - `word_count`=0 -> `error`=1, no `write_en`, `busy`=0.
  - `word_count`=65 -> `error`=1, no `write_en`, `busy`=0.
  - A following valid `start` clears `error`.
- Ignored `start`: pulse `start` with `word_count`=5 during a 3-word load -> the load still ends after exactly 3 writes.
- Reset mid-load: reset after word 1 plus 2 bytes of word 2 -> no further writes. A new 1-word load then writes address 0 with only the new bytes, with no stale lanes.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and writes
// them to consecutive instruction memory indices while holding the core stalled.
module instr_mem_loader #(
    parameter int unsigned MEMORY_SIZE = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] word_count,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        write_en,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic        core_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [31:0] MemSize = 32'(MEMORY_SIZE);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StWrite,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [31:0] index_q, index_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] waddr_q, waddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic        handshake;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            index_q    <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        error_d    = error_q;

        byte_ready    = (state_q == StCollect);
        write_en      = (state_q == StWrite);
        busy          = (state_q == StCollect) || (state_q == StWrite);
        core_hold     = busy;
        done          = done_q;
        error         = error_q;
        write_address = waddr_q;
        write_data    = wdata_q;
        handshake     = byte_valid && byte_ready;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    if ((word_count == '0) || (word_count > MemSize)) begin
                        error_d = 1'b1;
                        done_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        count_d    = word_count;
                        index_d    = '0;
                        byte_cnt_d = '0;
                        word_d     = '0;
                        done_d     = 1'b0;
                        error_d    = 1'b0;
                        state_d    = StCollect;
                    end
                end
            end
            StCollect: begin
                if (handshake) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    unique case (byte_cnt_q)
                        2'd0: word_d[7:0]   = byte_in;
                        2'd1: word_d[15:8]  = byte_in;
                        2'd2: word_d[23:16] = byte_in;
                        2'd3: word_d[31:24] = byte_in;
                        default: ;
                    endcase
                    // Latch the write port on the last byte so it is valid throughout WRITE.
                    if (byte_cnt_q == 2'd3) begin
                        waddr_d = index_q;
                        wdata_d = {byte_in, word_q[23:0]};
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (index_q == count_q - 32'd1) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    index_d = index_q + 32'd1;
                    state_d = StCollect;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: a scoreboard of expected writes is filled as
// words are streamed and drained by a monitor on every write_en pulse.
module tb_instr_mem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] word_count;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        write_en;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int n_writes = 0;
    logic [63:0] exp_q[$];

    instr_mem_loader #(.MEMORY_SIZE(64)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .word_count    (word_count),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .write_en      (write_en),
        .write_address (write_address),
        .write_data    (write_data),
        .core_hold     (core_hold),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && write_en) begin
            logic [63:0] e;
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%08h, required no write",
                         write_address, write_data);
            end else begin
                e = exp_q.pop_front();
                if (write_address !== e[63:32] || write_data !== e[31:0]) begin
                    errors++;
                    $display("FAIL write_word: addr=%0d data=%08h, required addr=%0d data=%08h",
                             write_address, write_data, e[63:32], e[31:0]);
                end
            end
            checks++;
            if (byte_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL write_cycle_flags: ready=%b done=%b busy=%b, required 0 0 1",
                         byte_ready, done, busy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] n, input bit expect_ok);
        start = 1'b1;
        word_count = n;
        tick();
        start = 1'b0;
        checks++;
        if (expect_ok) begin
            if (busy !== 1'b1 || core_hold !== 1'b1 || byte_ready !== 1'b1 || error !== 1'b0) begin
                errors++;
                $display("FAIL start_accept: busy=%b hold=%b ready=%b err=%b, required 1 1 1 0",
                         busy, core_hold, byte_ready, error);
            end
        end else begin
            if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL start_reject: err=%b busy=%b done=%b ready=%b, required 1 0 0 0",
                         error, busy, done, byte_ready);
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int guard;
        if (stall) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(0, 2)) tick();
        end
        byte_valid = 1'b1;
        byte_in = b;
        guard = 0;
        @(negedge clk);
        while (!byte_ready && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL byte_ready_timeout: ready=%b, required 1", byte_ready);
            byte_valid = 1'b0;
            return;
        end
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input bit stall);
        exp_q.push_back({addr, w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], stall);
    endtask

    task automatic wait_not_busy();
        int guard = 0;
        while (busy && guard < 50) begin
            guard++;
            tick();
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        start_load(32'd2, 1'b1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({byte_ready, write_en, core_hold, busy, done, error} !== 6'b0 ||
            write_address !== 32'd0 || write_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_async: flags=%b addr=%08h data=%08h, required all 0",
                     {byte_ready, write_en, core_hold, busy, done, error},
                     write_address, write_data);
        end
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();
        checks++;
        if (byte_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b done=%b, required 0 0 0",
                     byte_ready, busy, done);
        end
    endtask

    task automatic test_single();
        int w0 = n_writes;
        start_load(32'd1, 1'b1);
        send_word(32'd0, 32'h0010_0513, 1'b0);
        wait_not_busy();
        checks++;
        if (done !== 1'b1 || core_hold !== 1'b0 || n_writes - w0 != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL single_word: done=%b hold=%b writes=%0d pending=%0d, required 1 0 1 0",
                     done, core_hold, n_writes - w0, exp_q.size());
        end
    endtask

    task automatic test_full();
        int w0 = n_writes;
        start_load(32'd64, 1'b1);
        for (int i = 0; i < 64; i++) send_word(i, 32'hA500_0000 + i, 1'b1);
        wait_not_busy();
        checks++;
        if (done !== 1'b1 || n_writes - w0 != 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_memory: done=%b writes=%0d pending=%0d, required 1 64 0",
                     done, n_writes - w0, exp_q.size());
        end
        checks++;
        if (write_address !== 32'd63 || write_data !== 32'hA500_003F || write_en !== 1'b0) begin
            errors++;
            $display("FAIL write_port_hold: addr=%0d data=%08h en=%b, required 63 a500003f 0",
                     write_address, write_data, write_en);
        end
    endtask

    task automatic test_range();
        logic [31:0] bad [2] = '{32'd0, 32'd65};
        int w0 = n_writes;
        for (int i = 0; i < 2; i++) begin
            start_load(bad[i], 1'b0);
            repeat (3) tick();
            checks++;
            if (n_writes != w0 || busy !== 1'b0 || error !== 1'b1) begin
                errors++;
                $display("FAIL range_%0d: writes=%0d busy=%b err=%b, required 0 0 1",
                         bad[i], n_writes - w0, busy, error);
            end
        end
        start_load(32'd1, 1'b1);
        send_word(32'd0, 32'hDEAD_BEEF, 1'b0);
        wait_not_busy();
        checks++;
        if (error !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL range_recover: err=%b done=%b, required 0 1", error, done);
        end
    endtask

    task automatic test_ignored_start();
        int w0 = n_writes;
        start_load(32'd3, 1'b1);
        send_word(32'd0, 32'h1111_0000, 1'b0);
        start = 1'b1;
        word_count = 32'd5;
        tick();
        start = 1'b0;
        send_word(32'd1, 32'h2222_0001, 1'b0);
        send_word(32'd2, 32'h3333_0002, 1'b0);
        wait_not_busy();
        repeat (10) tick();
        checks++;
        if (n_writes - w0 != 3 || done !== 1'b1 || busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ignored_start: writes=%0d done=%b busy=%b, required 3 1 0",
                     n_writes - w0, done, busy);
        end
    endtask

    task automatic test_reset_midload();
        int w0;
        start_load(32'd3, 1'b1);
        send_word(32'd0, 32'h0102_0304, 1'b0);
        send_word(32'd1, 32'h0506_0708, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        w0 = n_writes;
        #2 reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if (n_writes != w0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_midload: writes=%0d busy=%b, required 0 0", n_writes - w0, busy);
        end
        start_load(32'd1, 1'b1);
        send_word(32'd0, 32'h4433_2211, 1'b0);
        wait_not_busy();
        checks++;
        if (n_writes - w0 != 1 || exp_q.size() != 0 || done !== 1'b1) begin
            errors++;
            $display("FAIL reload_after_reset: writes=%0d pending=%0d done=%b, required 1 0 1",
                     n_writes - w0, exp_q.size(), done);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        word_count = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        test_reset();
        test_single();
        test_full();
        test_range();
        test_ignored_start();
        test_reset_midload();
        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
